block_drawer: RTL and testbench

- Downstream of the coordinate-load stage; consumes its registered x/y/colour once the load stage asserts its done flag.
- Rasterises one BLOCK_W x BLOCK_H block into per-pixel writes for the VGA adapter: plot, x, y, colour.
- The colour input is already black during erase passes, so one drawer serves both draw and erase.

---
 rtl/block_pkg.sv | 29 ++
 rtl/block_offset_counter.sv | 61 ++++++
 rtl/block_drawer.sv | 138 +++++++++++++
 tb/tb_block_drawer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared constants, widths and state encoding for the block rasteriser.
// Included by the offset counter and the drawer top.
package block_pkg;

  localparam int BLOCK_W  = 4;
  localparam int BLOCK_H  = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int DX_W     = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int DY_W     = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } drawer_state_e;

  // Sums carry one extra bit so an offset past the last column/row is caught.
  function automatic logic in_screen(input logic [X_W:0] sum_x,
                                     input logic [Y_W:0] sum_y);
    return (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/block_offset_counter.sv
// Raster-order dx/dy offset generator for one block; dx advances fastest.
// last flags the final (BLOCK_W-1, BLOCK_H-1) offset.
module block_offset_counter
  import block_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic            last
);

  localparam logic [DX_W-1:0] DX_MAX = DX_W'(BLOCK_W - 1);
  localparam logic [DY_W-1:0] DY_MAX = DY_W'(BLOCK_H - 1);

  logic [DX_W-1:0] dx_q, dx_d;
  logic [DY_W-1:0] dy_q, dy_d;

  // Next offset: clear wins over enable; dx wrap carries into dy.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = DX_W'(0);
      dy_d = DY_W'(0);
    end else if (enable) begin
      if (dx_q == DX_MAX) begin
        dx_d = DX_W'(0);
        if (dy_q == DY_MAX) begin
          dy_d = DY_W'(0);
        end else begin
          dy_d = dy_q + DY_W'(1);
        end
      end else begin
        dx_d = dx_q + DX_W'(1);
        dy_d = dy_q;
      end
    end else begin
      dx_d = dx_q;
      dy_d = dy_q;
    end
  end

  // Offset registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= DX_W'(0);
      dy_q <= DY_W'(0);
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == DX_MAX) && (dy_q == DY_MAX);

endmodule

// File: rtl/block_drawer.sv
// Turns one latched block request into BLOCK_W x BLOCK_H clipped pixel writes,
// then a one-cycle done pulse. All outputs are registered.
module block_drawer
  import block_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      base_x,
  input  logic [Y_W-1:0]      base_y,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                done
);

  drawer_state_e state_q, state_d;

  logic [X_W-1:0]      base_x_q, base_x_d;
  logic [Y_W-1:0]      base_y_q, base_y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                busy_q, busy_d;
  logic                plot_q, plot_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_out_q, colour_out_d;

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            last;
  logic            cnt_clear;
  logic            cnt_enable;
  logic [X_W:0]    sum_x;
  logic [Y_W:0]    sum_y;

  assign cnt_clear  = (state_q == IDLE) && start;
  assign cnt_enable = (state_q == DRAW);

  block_offset_counter u_offset (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  assign sum_x = {1'b0, base_x_q} + (X_W+1)'(dx);
  assign sum_y = {1'b0, base_y_q} + (Y_W+1)'(dy);

  // Next state and registered-output values.
  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    busy_d       = 1'b0;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    colour_out_d = colour_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_x_d = base_x;
          base_y_d = base_y;
          colour_d = colour_in;
          busy_d   = 1'b1;
          state_d  = DRAW;
        end else begin
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      DRAW: begin
        busy_d       = 1'b1;
        plot_d       = in_screen(sum_x, sum_y);
        x_d          = sum_x[X_W-1:0];
        y_d          = sum_y[Y_W-1:0];
        colour_out_d = colour_q;
        if (last) begin
          state_d = DONE;
        end else begin
          state_d = DRAW;
        end
      end
      DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_x_q     <= X_W'(0);
      base_y_q     <= Y_W'(0);
      colour_q     <= COLOUR_BLACK;
      busy_q       <= 1'b0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      x_q          <= X_W'(0);
      y_q          <= Y_W'(0);
      colour_out_q <= COLOUR_BLACK;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      busy_q       <= busy_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_out_q <= colour_out_d;
    end
  end

  assign busy       = busy_q;
  assign plot       = plot_q;
  assign done       = done_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_out_q;

endmodule

// File: tb/tb_block_drawer.sv
// Scoreboard bench for block_drawer: stimulus pushes cycle-stamped expected
// pixels/done pulses, a negedge monitor pops and compares them.
module tb_block_drawer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_x = 8'd0;
  logic [6:0] base_y = 7'd0;
  logic [2:0] colour_in = 3'b000;
  logic       busy, plot, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   plot_cnt = 0;
  bit   mon_en = 1'b0;

  block_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_x     (base_x),
    .base_y     (base_y),
    .colour_in  (colour_in),
    .busy       (busy),
    .plot       (plot),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected pixels of a block accepted at edge n; only the first npix slots.
  task automatic push_block(input int n, input int bx, input int by,
                            input logic [2:0] c, input int npix);
    exp_t e;
    for (int k = 0; k < npix; k++) begin
      int sx, sy;
      sx = bx + (k % 4);
      sy = by + (k / 4);
      if (sx < 160 && sy < 120) begin
        e.cyc = n + 1 + k; e.is_done = 1'b0;
        e.x = sx[7:0]; e.y = sy[6:0]; e.c = c;
        sb.push_back(e);
      end
    end
    if (npix == 16) begin
      e.cyc = n + 17; e.is_done = 1'b1; e.x = 8'd0; e.y = 7'd0; e.c = 3'b000;
      sb.push_back(e);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Issue a one-cycle start; returns the accepting edge number.
  task automatic issue(input int bx, input int by, input logic [2:0] c,
                       input bit expect_block, output int n);
    @(negedge clk);
    base_x = 8'(bx); base_y = 7'(by); colour_in = c; start = 1'b1;
    n = cyc + 1;
    if (expect_block) push_block(n, bx, by, c, 16);
    @(negedge clk);
    start = 1'b0;
    base_x = 8'd77; base_y = 7'd33; colour_in = 3'b010;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_busy_idle"}, int'(busy), 0);
  endtask

  // Monitor: every plot/done must match the head of the scoreboard in cycle and value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (plot === 1'b1 || done === 1'b1) begin
        checks++;
        if (plot === 1'b1) plot_cnt++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cyc=%0d plot=%0b done=%0b x=%0d y=%0d (none expected)",
                   cyc, plot, done, x_out, y_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.cyc != cyc || e.is_done != done || plot === done ||
              (!e.is_done && (x_out !== e.x || y_out !== e.y || colour_out !== e.c))) begin
            failures++;
            $display("FAIL pixel actual cyc=%0d plot=%0b done=%0b x=%0d y=%0d c=%0b required cyc=%0d done=%0b x=%0d y=%0d c=%0b",
                     cyc, plot, done, x_out, y_out, colour_out,
                     e.cyc, e.is_done, e.x, e.y, e.c);
          end
        end
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_during_output cyc=%0d actual=%0b required=1", cyc, busy);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_output cyc=%0d actual plot=0 done=0 required cyc=%0d done=%0b x=%0d y=%0d",
                 cyc, e.cyc, e.is_done, e.x, e.y);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int n, base_cnt;

    // Reset then 5 idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_plot", int'(plot), 0);
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_xy", int'({x_out, y_out, colour_out}), 0);
    end
    mon_en = 1'b1;

    // Plain block: 16 in-screen pixels.
    base_cnt = plot_cnt;
    issue(8, 100, 3'b101, 1'b1, n);
    check("busy_after_start", int'(busy), 1);
    drain("block_8_100");
    check("count_8_100", plot_cnt - base_cnt, 16);

    // Bottom-right corner: only 4 visible pixels, same timing.
    base_cnt = plot_cnt;
    issue(158, 118, 3'b111, 1'b1, n);
    drain("block_clip");
    check("count_clip", plot_cnt - base_cnt, 4);

    // Start during DRAW is ignored.
    base_cnt = plot_cnt;
    issue(30, 10, 3'b011, 1'b1, n);
    while (cyc < n + 5) @(negedge clk);
    base_x = 8'd40; base_y = 7'd50; colour_in = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("block_ignore");
    check("count_ignore", plot_cnt - base_cnt, 16);

    // Reset at pixel 7 aborts, then a black block at the origin.
    @(negedge clk);
    base_x = 8'd50; base_y = 7'd20; colour_in = 3'b110; start = 1'b1;
    n = cyc + 1;
    push_block(n, 50, 20, 3'b110, 7);
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + 7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_more", sb.size(), 0);
    base_cnt = plot_cnt;
    issue(0, 0, 3'b000, 1'b1, n);
    drain("block_black");
    check("count_black", plot_cnt - base_cnt, 16);

    // Start held 40 cycles: blocks accepted every 18 edges.
    @(negedge clk);
    base_x = 8'd20; base_y = 7'd60; colour_in = 3'b110; start = 1'b1;
    n = cyc + 1;
    push_block(n,      20, 60, 3'b110, 16);
    push_block(n + 18, 20, 60, 3'b110, 16);
    push_block(n + 36, 20, 60, 3'b110, 16);
    repeat (40) @(negedge clk);
    start = 1'b0;
    drain("block_held");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
